// File: rtl/perfmon_sampler_if.sv
// perfmon_sampler_if
//   MMIO port between an initiator (the sampler) and the perfmon register
//   block, behind the core's MMIO arbiter.
//   bus_req         initiator requests the port from the arbiter
//   bus_gnt         arbiter grant, valid in the same cycle
//   perfmons_enable access strobe (bus_req & bus_gnt)
//   addr_bus        7-bit register address
//   data_store      32-bit write data
//   data_fetch      32-bit read data, combinational in the access cycle
interface perfmon_sampler_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        perfmons_enable;
  logic [6:0]  addr_bus;
  logic [31:0] data_store;
  logic [31:0] data_fetch;

  modport master (
    output bus_req, perfmons_enable, addr_bus, data_store,
    input  bus_gnt, data_fetch
  );

  modport slave (
    input  bus_req, perfmons_enable, addr_bus, data_store,
    output bus_gnt, data_fetch
  );
endinterface

// File: rtl/perfmon_sampler.sv
// perfmon_sampler
//   Snapshots the perfmon counters over MMIO on request and buffers the
//   snapshots in a small FIFO; also issues watchdog pets (write of 0 to 0x30).
//   64-bit counters are read high-low-high and retried on a high-word change.
// Ports:
//   soc_clk, rst_n        clock, synchronous active-low reset
//   sample_trigger        pulse: take a snapshot (dropped if no slot/pending)
//   pet_req               pulse: pet the watchdog (coalesced)
//   mmio                  MMIO initiator port (perfmon_sampler_if.master)
//   snap_valid/snap_ready FIFO head handshake
//   snap_soc/core/miss/retired/torn  head record fields
//   drop_count            saturating count of dropped triggers
//   busy                  sequencer not idle
module perfmon_sampler #(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                     soc_clk,
  input  logic                     rst_n,
  input  logic                     sample_trigger,
  input  logic                     pet_req,
  perfmon_sampler_if.master        mmio,
  output logic                     snap_valid,
  input  logic                     snap_ready,
  output logic [63:0]              snap_soc,
  output logic [63:0]              snap_core,
  output logic [31:0]              snap_miss,
  output logic [31:0]              snap_retired,
  output logic                     snap_torn,
  output logic [7:0]               drop_count,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [CW:0]   DEPTH_W     = (CW+1)'(DEPTH);
  localparam logic [RW-1:0] MAX_RETRY_W = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE, S_PET, S_SH1, S_SL, S_SH2, S_CH1, S_CL, S_CH2, S_MISS, S_RET, S_PUSH
  } state_t;

  typedef struct packed {
    logic [63:0] soc;
    logic [63:0] core;
    logic [31:0] miss;
    logic [31:0] ret;
    logic        torn;
  } rec_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          state, state_nxt;
  logic            bus_req, take_pet, take_trig, push, pop;
  logic [6:0]      addr;
  logic            pet_pend, trig_pend, trig_accept, in_flight;
  logic            hi_match, retry_ok;
  logic [7:0]      drop_cnt;
  logic [31:0]     hi_first, lo_word;
  logic [RW-1:0]   retry_cnt;
  rec_t            rec_cur;
  rec_t            mem [DEPTH];
  rec_t            head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     need, room;

  assign hi_match = (mmio.data_fetch == hi_first);
  assign retry_ok = (retry_cnt < MAX_RETRY_W);

  always_ff @(posedge soc_clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    addr      = 7'h00;
    take_pet  = 1'b0;
    take_trig = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (pet_pend) begin
          state_nxt = S_PET;
          take_pet  = 1'b1;
        end else if (trig_pend) begin
          state_nxt = S_SH1;
          take_trig = 1'b1;
        end
      end
      S_PET:  begin bus_req = 1'b1; addr = 7'h30; if (mmio.bus_gnt) state_nxt = S_IDLE; end
      S_SH1:  begin bus_req = 1'b1; addr = 7'h10; if (mmio.bus_gnt) state_nxt = S_SL;   end
      S_SL:   begin bus_req = 1'b1; addr = 7'h14; if (mmio.bus_gnt) state_nxt = S_SH2;  end
      S_SH2: begin
        bus_req = 1'b1;
        addr    = 7'h10;
        if (mmio.bus_gnt) state_nxt = (!hi_match && retry_ok) ? S_SL : S_CH1;
      end
      S_CH1:  begin bus_req = 1'b1; addr = 7'h18; if (mmio.bus_gnt) state_nxt = S_CL;   end
      S_CL:   begin bus_req = 1'b1; addr = 7'h1C; if (mmio.bus_gnt) state_nxt = S_CH2;  end
      S_CH2: begin
        bus_req = 1'b1;
        addr    = 7'h18;
        if (mmio.bus_gnt) state_nxt = (!hi_match && retry_ok) ? S_CL : S_MISS;
      end
      S_MISS: begin bus_req = 1'b1; addr = 7'h28; if (mmio.bus_gnt) state_nxt = S_RET;  end
      S_RET:  begin bus_req = 1'b1; addr = 7'h2C; if (mmio.bus_gnt) state_nxt = S_PUSH; end
      S_PUSH: begin push = 1'b1; state_nxt = S_IDLE; end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mmio.bus_req         = bus_req;
  assign mmio.perfmons_enable = bus_req & mmio.bus_gnt;
  assign mmio.addr_bus        = addr;
  assign mmio.data_store      = 32'h0;
  assign busy                 = (state != S_IDLE);

  // A trigger reserves a slot: occupied + in-flight record must stay below
  // DEPTH, counting a pop in this cycle as a freed slot.
  assign pop         = snap_valid & snap_ready;
  assign in_flight   = (state != S_IDLE) && (state != S_PET);
  assign need        = {1'b0, count} + (CW+1)'(in_flight);
  assign room        = DEPTH_W + (CW+1)'(pop);
  assign trig_accept = sample_trigger && !trig_pend && (need < room);

  always_ff @(posedge soc_clk) begin
    if (!rst_n) begin
      pet_pend  <= 1'b0;
      trig_pend <= 1'b0;
      drop_cnt  <= 8'h00;
    end else begin
      if (pet_req)       pet_pend <= 1'b1;
      else if (take_pet) pet_pend <= 1'b0;
      if (trig_accept)    trig_pend <= 1'b1;
      else if (take_trig) trig_pend <= 1'b0;
      if (sample_trigger && !trig_accept) drop_cnt <= sat_inc8(drop_cnt);
    end
  end

  assign drop_count = drop_cnt;

  // Capture path: only on granted edges. On a high-word mismatch the new
  // high becomes the reference and the low word is re-read; once retries
  // run out the latest high/low pair is kept and the record marked torn.
  always_ff @(posedge soc_clk) begin
    case (state)
      S_IDLE: begin
        if (take_trig) begin
          retry_cnt    <= '0;
          rec_cur.torn <= 1'b0;
        end
      end
      S_SH1, S_CH1: if (mmio.bus_gnt) hi_first <= mmio.data_fetch;
      S_SL, S_CL:   if (mmio.bus_gnt) lo_word  <= mmio.data_fetch;
      S_SH2, S_CH2: begin
        if (mmio.bus_gnt) begin
          if (!hi_match && retry_ok) begin
            hi_first  <= mmio.data_fetch;
            retry_cnt <= retry_cnt + RW'(1);
          end else begin
            if (state == S_SH2) rec_cur.soc  <= {mmio.data_fetch, lo_word};
            else                rec_cur.core <= {mmio.data_fetch, lo_word};
            retry_cnt <= '0;
            if (!hi_match) rec_cur.torn <= 1'b1;
          end
        end
      end
      S_MISS: if (mmio.bus_gnt) rec_cur.miss <= mmio.data_fetch;
      S_RET:  if (mmio.bus_gnt) rec_cur.ret  <= mmio.data_fetch;
      default: ;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (push) mem[wr_ptr] <= rec_cur;
  end

  always_ff @(posedge soc_clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Head fields are forced to zero while empty so reset leaves them clear.
  assign snap_valid   = (count != '0);
  assign head         = mem[rd_ptr];
  assign snap_soc     = snap_valid ? head.soc  : 64'h0;
  assign snap_core    = snap_valid ? head.core : 64'h0;
  assign snap_miss    = snap_valid ? head.miss : 32'h0;
  assign snap_retired = snap_valid ? head.ret  : 32'h0;
  assign snap_torn    = snap_valid & head.torn;

endmodule

// File: tb/tb_perfmon_sampler.sv
module tb_perfmon_sampler;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] soc;
    logic [63:0] core;
    logic [31:0] miss;
    logic [31:0] ret;
    logic        torn;
  } rec_t;

  logic        soc_clk;
  logic        rst_n;
  logic        sample_trigger;
  logic        pet_req;
  logic        snap_valid;
  logic        snap_ready;
  logic [63:0] snap_soc;
  logic [63:0] snap_core;
  logic [31:0] snap_miss;
  logic [31:0] snap_retired;
  logic        snap_torn;
  logic [7:0]  drop_count;
  logic        busy;

  perfmon_sampler_if mif ();

  perfmon_sampler #(.DEPTH(DEPTH), .MAX_RETRY(3)) dut (
    .soc_clk        (soc_clk),
    .rst_n          (rst_n),
    .sample_trigger (sample_trigger),
    .pet_req        (pet_req),
    .mmio           (mif),
    .snap_valid     (snap_valid),
    .snap_ready     (snap_ready),
    .snap_soc       (snap_soc),
    .snap_core      (snap_core),
    .snap_miss      (snap_miss),
    .snap_retired   (snap_retired),
    .snap_torn      (snap_torn),
    .drop_count     (drop_count),
    .busy           (busy)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  int n_vec  = 0;
  int n_miss = 0;
  int model_drops = 0;

  logic [6:0] exp_addr_q [$];
  rec_t       exp_rec_q  [$];
  logic [6:0] mon_addr;
  rec_t       mon_rec;
  logic [6:0] basic_addr [8];

  // Responder register file; the SOC high word can follow a per-read table.
  logic [31:0] r_soc_hi, r_soc_lo, r_core_hi, r_core_lo, r_miss, r_ret;
  logic [31:0] hi_tab [8];
  int          hi_len  = 0;
  int          hi_base = 0;
  int          hi_reads = 0;
  int          hi_idx;

  assign hi_idx = hi_reads - hi_base;

  always_comb begin
    mif.data_fetch = 32'h0;
    case (mif.addr_bus)
      7'h10:   mif.data_fetch = (hi_idx < hi_len) ? hi_tab[hi_idx[2:0]] : r_soc_hi;
      7'h14:   mif.data_fetch = r_soc_lo;
      7'h18:   mif.data_fetch = r_core_hi;
      7'h1C:   mif.data_fetch = r_core_lo;
      7'h28:   mif.data_fetch = r_miss;
      7'h2C:   mif.data_fetch = r_ret;
      default: mif.data_fetch = 32'h0;
    endcase
  end

  always @(posedge soc_clk) begin
    if (mif.perfmons_enable && mif.addr_bus == 7'h10) hi_reads <= hi_reads + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic set_resp(input logic [31:0] sh, sl, ch, cl, m, r);
    r_soc_hi  = sh;
    r_soc_lo  = sl;
    r_core_hi = ch;
    r_core_lo = cl;
    r_miss    = m;
    r_ret     = r;
    hi_len    = 0;
    hi_base   = hi_reads;
  endtask

  function automatic rec_t mk_rec(input logic [63:0] s, c, input logic [31:0] m, r,
                                  input logic t);
    rec_t x;
    x.soc = s; x.core = c; x.miss = m; x.ret = r; x.torn = t;
    return x;
  endfunction

  // Scoreboard push: predicts acceptance from the outstanding record count.
  task automatic expect_snap(input int extra, input rec_t r);
    if (exp_rec_q.size() < DEPTH) begin
      exp_addr_q.push_back(7'h10);
      exp_addr_q.push_back(7'h14);
      exp_addr_q.push_back(7'h10);
      for (int i = 0; i < extra; i++) begin
        exp_addr_q.push_back(7'h14);
        exp_addr_q.push_back(7'h10);
      end
      exp_addr_q.push_back(7'h18);
      exp_addr_q.push_back(7'h1C);
      exp_addr_q.push_back(7'h18);
      exp_addr_q.push_back(7'h28);
      exp_addr_q.push_back(7'h2C);
      exp_rec_q.push_back(r);
    end else begin
      model_drops++;
    end
  endtask

  task automatic pulse_trig();
    sample_trigger = 1'b1;
    tick();
    sample_trigger = 1'b0;
  endtask

  task automatic drain(input string tag);
    snap_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (exp_rec_q.size() == 0 && exp_addr_q.size() == 0 && !busy) break;
      tick();
    end
    chk({tag, "_rec_left"}, 64'(exp_rec_q.size()), 64'h0);
    chk({tag, "_acc_left"}, 64'(exp_addr_q.size()), 64'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, 64'(mif.bus_req), 64'h0);
    chk({tag, "_enable"},  64'(mif.perfmons_enable), 64'h0);
    chk({tag, "_addr"},    64'(mif.addr_bus), 64'h0);
    chk({tag, "_dstore"},  64'(mif.data_store), 64'h0);
    chk({tag, "_valid"},   64'(snap_valid), 64'h0);
    chk({tag, "_soc"},     snap_soc, 64'h0);
    chk({tag, "_core"},    snap_core, 64'h0);
    chk({tag, "_miss"},    64'(snap_miss), 64'h0);
    chk({tag, "_ret"},     64'(snap_retired), 64'h0);
    chk({tag, "_torn"},    64'(snap_torn), 64'h0);
    chk({tag, "_drops"},   64'(drop_count), 64'h0);
    chk({tag, "_busy"},    64'(busy), 64'h0);
  endtask

  // Bus and FIFO monitor, sampled mid-cycle.
  always @(negedge soc_clk) begin
    if (rst_n && mif.perfmons_enable) begin
      chk("dstore", 64'(mif.data_store), 64'h0);
      if (exp_addr_q.size() == 0) begin
        chk("acc_extra", 64'(mif.perfmons_enable), 64'h0);
      end else begin
        mon_addr = exp_addr_q.pop_front();
        chk("acc_addr", 64'(mif.addr_bus), 64'(mon_addr));
      end
    end
    if (rst_n && snap_valid && snap_ready) begin
      if (exp_rec_q.size() == 0) begin
        chk("rec_extra", 64'(snap_valid), 64'h0);
      end else begin
        mon_rec = exp_rec_q.pop_front();
        chk("rec_soc",  snap_soc, mon_rec.soc);
        chk("rec_core", snap_core, mon_rec.core);
        chk("rec_miss", 64'(snap_miss), 64'(mon_rec.miss));
        chk("rec_ret",  64'(snap_retired), 64'(mon_rec.ret));
        chk("rec_torn", 64'(snap_torn), 64'(mon_rec.torn));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rec_t r;
    basic_addr[0] = 7'h10; basic_addr[1] = 7'h14; basic_addr[2] = 7'h10;
    basic_addr[3] = 7'h18; basic_addr[4] = 7'h1C; basic_addr[5] = 7'h18;
    basic_addr[6] = 7'h28; basic_addr[7] = 7'h2C;
    rst_n = 1'b0;
    sample_trigger = 1'b0;
    pet_req = 1'b0;
    snap_ready = 1'b1;
    mif.bus_gnt = 1'b1;
    set_resp(32'h1, 32'h5, 32'h2, 32'h3, 32'd7, 32'd9);
    repeat (3) tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Basic snapshot with cycle-exact timing.
    r = mk_rec(64'h1_0000_0005, 64'h2_0000_0003, 32'd7, 32'd9, 1'b0);
    expect_snap(0, r);
    pulse_trig();
    chk("c1_busy", 64'(busy), 64'h0);
    chk("c1_en", 64'(mif.perfmons_enable), 64'h0);
    for (int k = 2; k <= 9; k++) begin
      tick();
      chk("basic_addr", 64'(mif.addr_bus), 64'(basic_addr[k-2]));
      chk("basic_en", 64'(mif.perfmons_enable), 64'h1);
    end
    tick();
    chk("c10_req", 64'(mif.bus_req), 64'h0);
    chk("c10_busy", 64'(busy), 64'h1);
    chk("c10_valid", 64'(snap_valid), 64'h0);
    tick();
    chk("c11_valid", 64'(snap_valid), 64'h1);
    drain("basic");

    // Tear recovery: high 1, then 2, then 2 stable.
    set_resp(32'h0, 32'h5, 32'h2, 32'h3, 32'd7, 32'd9);
    hi_tab[0] = 32'h1; hi_tab[1] = 32'h2; hi_tab[2] = 32'h2; hi_len = 3;
    expect_snap(1, mk_rec(64'h2_0000_0005, 64'h2_0000_0003, 32'd7, 32'd9, 1'b0));
    pulse_trig();
    drain("tear");

    // High word moves on every read: retries exhausted, record torn.
    set_resp(32'h0, 32'h5, 32'h2, 32'h3, 32'd7, 32'd9);
    for (int i = 0; i < 5; i++) hi_tab[i] = 32'(i + 1);
    hi_len = 5;
    expect_snap(3, mk_rec(64'h5_0000_0005, 64'h2_0000_0003, 32'd7, 32'd9, 1'b1));
    pulse_trig();
    drain("torn");

    // Grant stall for 5 cycles in SL.
    set_resp(32'hA, 32'hB, 32'hC, 32'hD, 32'd11, 32'd13);
    expect_snap(0, mk_rec(64'hA_0000_000B, 64'hC_0000_000D, 32'd11, 32'd13, 1'b0));
    pulse_trig();
    tick();
    for (int k = 3; k <= 7; k++) begin
      tick();
      mif.bus_gnt = 1'b0;
      #1;
      chk("stall_req", 64'(mif.bus_req), 64'h1);
      chk("stall_addr", 64'(mif.addr_bus), 64'h14);
      chk("stall_en", 64'(mif.perfmons_enable), 64'h0);
    end
    tick();
    mif.bus_gnt = 1'b1;
    repeat (7) tick();
    chk("stall_c15_valid", 64'(snap_valid), 64'h0);
    tick();
    chk("stall_c16_valid", 64'(snap_valid), 64'h1);
    drain("stall");

    // Overflow: 7 triggers into a 4-deep FIFO with no consumer.
    snap_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_resp(32'(i + 1), 32'h100 + 32'(i), 32'h10 + 32'(i), 32'h200 + 32'(i),
               32'(i * 3), 32'(i * 5));
      expect_snap(0, mk_rec({32'(i + 1), 32'h100 + 32'(i)}, {32'h10 + 32'(i), 32'h200 + 32'(i)},
                            32'(i * 3), 32'(i * 5), 1'b0));
      pulse_trig();
      repeat (14) tick();
    end
    chk("ovf_drops", 64'(drop_count), 64'(model_drops));
    chk("ovf_valid", 64'(snap_valid), 64'h1);
    chk("ovf_busy", 64'(busy), 64'h0);
    drain("ovf");
    set_resp(32'h77, 32'h78, 32'h79, 32'h7A, 32'h7B, 32'h7C);
    expect_snap(0, mk_rec(64'h77_0000_0078, 64'h79_0000_007A, 32'h7B, 32'h7C, 1'b0));
    pulse_trig();
    drain("wrap");

    // Pet and trigger together: pet goes first.
    set_resp(32'h3, 32'h4, 32'h5, 32'h6, 32'd1, 32'd2);
    exp_addr_q.push_back(7'h30);
    expect_snap(0, mk_rec(64'h3_0000_0004, 64'h5_0000_0006, 32'd1, 32'd2, 1'b0));
    sample_trigger = 1'b1;
    pet_req = 1'b1;
    tick();
    sample_trigger = 1'b0;
    pet_req = 1'b0;
    tick();
    chk("pet_c2_addr", 64'(mif.addr_bus), 64'h30);
    chk("pet_c2_dstore", 64'(mif.data_store), 64'h0);
    drain("pet_first");

    // Pet requested mid-snapshot is serviced right after PUSH.
    expect_snap(0, mk_rec(64'h3_0000_0004, 64'h5_0000_0006, 32'd1, 32'd2, 1'b0));
    pulse_trig();
    repeat (4) tick();
    pet_req = 1'b1;
    exp_addr_q.push_back(7'h30);
    tick();
    pet_req = 1'b0;
    repeat (6) tick();
    chk("pet_c12_addr", 64'(mif.addr_bus), 64'h30);
    chk("pet_c12_en", 64'(mif.perfmons_enable), 64'h1);
    drain("pet_mid");

    // Reset during CL with records queued and drops counted.
    snap_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_snap(0, mk_rec(64'h3_0000_0004, 64'h5_0000_0006, 32'd1, 32'd2, 1'b0));
      pulse_trig();
      repeat (14) tick();
    end
    expect_snap(0, mk_rec(64'h3_0000_0004, 64'h5_0000_0006, 32'd1, 32'd2, 1'b0));
    pulse_trig();
    repeat (5) tick();
    chk("rst_cl_addr", 64'(mif.addr_bus), 64'h1C);
    rst_n = 1'b0;
    tick();
    chk_all_zero("midrst");
    exp_addr_q.delete();
    exp_rec_q.delete();
    model_drops = 0;
    rst_n = 1'b1;
    repeat (15) tick();
    chk("post_rst_valid", 64'(snap_valid), 64'h0);
    chk("post_rst_busy", 64'(busy), 64'h0);
    chk("post_rst_drops", 64'(drop_count), 64'(model_drops));

    // Recovery snapshot after reset.
    set_resp(32'h9, 32'h8, 32'h7, 32'h6, 32'd5, 32'd4);
    expect_snap(0, mk_rec(64'h9_0000_0008, 64'h7_0000_0006, 32'd5, 32'd4, 1'b0));
    pulse_trig();
    drain("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
